// File: rtl/paddle_ai.sv
// Computer-controlled paddle: returns to mid-field when the ball recedes, waits a
// reaction delay once it approaches, then tracks ball_y with periodic dy decisions.
module paddle_ai #(
   parameter int BIT_WIDTH     = 10,
   parameter int MAX_Y         = 480,
   parameter int PADDLE_LENGTH = 80,
   parameter int DEAD_ZONE     = 4,
   parameter int REACT_CYCLES  = 3,
   parameter int DECIDE_PERIOD = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 pause,
   input  logic                 side,
   input  logic [BIT_WIDTH-1:0] ball_y,
   input  logic                 ball_dir_x,
   input  logic [BIT_WIDTH-1:0] paddle_y,
   output logic [1:0]           dy,
   output logic [1:0]           ai_state
);

   localparam int EW = BIT_WIDTH + 2;
   localparam int TW = (DECIDE_PERIOD > 1) ? $clog2(DECIDE_PERIOD) : 1;
   localparam int RW = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;

   localparam logic [TW-1:0]        TICK_LAST  = TW'(DECIDE_PERIOD - 1);
   localparam logic [RW-1:0]        REACT_LOAD = RW'(REACT_CYCLES - 1);
   localparam logic signed [EW-1:0] REST_Y     = EW'(MAX_Y / 2);
   localparam logic signed [EW-1:0] HALF_LEN   = EW'(PADDLE_LENGTH / 2);
   localparam logic signed [EW-1:0] DZ_POS     = EW'(DEAD_ZONE);
   localparam logic signed [EW-1:0] DZ_NEG     = -DZ_POS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RETURN = 2'd1,
      S_WAIT   = 2'd2,
      S_TRACK  = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [1:0]             r_dy, w_dy_nxt;
   logic [RW-1:0]          r_react, w_react_nxt;
   logic [TW-1:0]          r_tick, w_tick_nxt;
   logic                   w_approach;
   logic                   w_tick;
   logic signed [EW-1:0]   w_target;
   logic signed [EW-1:0]   w_center;
   logic signed [EW-1:0]   w_err;

   assign w_approach = (side == 1'b0) ? ball_dir_x : ~ball_dir_x;
   assign w_tick     = (r_tick == TICK_LAST);
   // Two guard bits keep target - center exact for every input combination.
   assign w_target   = (r_state == S_TRACK) ? $signed({2'b00, ball_y}) : REST_Y;
   assign w_center   = $signed({2'b00, paddle_y}) + HALF_LEN;
   assign w_err      = w_target - w_center;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dy    <= '0;
         r_react <= '0;
         r_tick  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dy    <= w_dy_nxt;
         r_react <= w_react_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dy_nxt    = r_dy;
      w_react_nxt = r_react;
      w_tick_nxt  = r_tick;

      if (!pause) begin
         w_tick_nxt = w_tick ? '0 : r_tick + TW'(1);

         if (w_tick && (r_state == S_RETURN || r_state == S_TRACK)) begin
            if (w_err > DZ_POS)      w_dy_nxt = 2'b01;
            else if (w_err < DZ_NEG) w_dy_nxt = 2'b10;
            else                     w_dy_nxt = 2'b00;
         end

         // State moves override the tick decision where they force dy to rest.
         case (r_state)
            S_IDLE: begin
               w_dy_nxt    = 2'b00;
               w_state_nxt = S_RETURN;
            end
            S_RETURN: begin
               if (w_approach) begin
                  w_state_nxt = S_WAIT;
                  w_react_nxt = REACT_LOAD;
                  w_dy_nxt    = 2'b00;
               end
            end
            S_WAIT: begin
               w_dy_nxt = 2'b00;
               if (!w_approach)           w_state_nxt = S_RETURN;
               else if (r_react == '0)    w_state_nxt = S_TRACK;
               else                       w_react_nxt = r_react - RW'(1);
            end
            S_TRACK: begin
               if (!w_approach) w_state_nxt = S_RETURN;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      if (!enable) begin
         w_state_nxt = S_IDLE;
         w_dy_nxt    = 2'b00;
      end
   end

   assign dy       = r_dy;
   assign ai_state = r_state;

endmodule

// File: tb/tb_paddle_ai.sv
// Directed bench for paddle_ai at default parameters (center = paddle_y + 40,
// rest target 240, dead zone 4, three WAIT cycles, decision every second edge).
module tb_paddle_ai;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       pause;
   logic       side;
   logic [9:0] ball_y;
   logic       ball_dir_x;
   logic [9:0] paddle_y;
   logic [1:0] dy;
   logic [1:0] ai_state;

   int n_assert = 0;
   int n_fail   = 0;

   paddle_ai dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .pause      (pause),
      .side       (side),
      .ball_y     (ball_y),
      .ball_dir_x (ball_dir_x),
      .paddle_y   (paddle_y),
      .dy         (dy),
      .ai_state   (ai_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b1;
      pause      = 1'b0;
      side       = 1'b0;
      ball_dir_x = 1'b0;
      ball_y     = 10'd0;
      paddle_y   = 10'd100;
      #1;
      chk("reset_state", ai_state, 2'd0);
      chk("reset_dy", dy, 2'b00);
      #11 rst_n = 1'b1;

      // Receding ball: RETURN toward 240, center 140, err +100
      step(1);
      chk("ret_state", ai_state, 2'd1);
      chk("ret_dy_pre_tick", dy, 2'b00);
      step(1);
      chk("ret_dy_tick", dy, 2'b01);

      // Approaching: three WAIT cycles with dy at rest, then TRACK, err -90
      ball_dir_x = 1'b1;
      ball_y     = 10'd50;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("wait_state", ai_state, 2'd2);
         chk("wait_dy", dy, 2'b00);
      end
      step(1);
      chk("track_state", ai_state, 2'd3);
      chk("track_dy_entry", dy, 2'b00);
      step(1);
      chk("track_dy_hold", dy, 2'b00);
      step(1);
      chk("track_dy_tick", dy, 2'b10);

      // Dead-zone boundaries around center 240
      paddle_y = 10'd200;
      ball_y   = 10'd244;
      step(2);
      chk("dz_plus4", dy, 2'b00);
      ball_y = 10'd245;
      step(2);
      chk("dz_plus5", dy, 2'b01);
      ball_y = 10'd235;
      step(1);
      chk("dz_between_ticks", dy, 2'b01);
      step(1);
      chk("dz_minus5", dy, 2'b10);
      ball_y = 10'd236;
      step(2);
      chk("dz_minus4", dy, 2'b00);

      // Asynchronous reset mid-TRACK while dy = 10
      ball_y   = 10'd50;
      paddle_y = 10'd100;
      step(2);
      chk("pre_reset_dy", dy, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_state", ai_state, 2'd0);
      chk("async_reset_dy", dy, 2'b00);
      step(1);
      chk("reset_held_state", ai_state, 2'd0);
      rst_n = 1'b1;

      // Restart, reach WAIT, then pause for 10 edges
      step(1);
      chk("restart_return", ai_state, 2'd1);
      step(1);
      chk("restart_wait", ai_state, 2'd2);
      step(1);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("pause_wait_state", ai_state, 2'd2);
         chk("pause_wait_dy", dy, 2'b00);
      end
      pause = 1'b0;
      step(1);
      chk("resume_last_wait", ai_state, 2'd2);
      step(1);
      chk("resume_track", ai_state, 2'd3);
      step(1);
      chk("resume_track_dy", dy, 2'b10);

      // Pause in TRACK freezes dy and the tick phase
      ball_y = 10'd300;
      pause  = 1'b1;
      step(3);
      chk("pause_track_state", ai_state, 2'd3);
      chk("pause_track_dy", dy, 2'b10);
      pause = 1'b0;
      step(1);
      chk("unpause_no_tick", dy, 2'b10);
      step(1);
      chk("unpause_tick", dy, 2'b01);

      // Ball turns away: RETURN keeps dy; WAIT aborted back to RETURN
      ball_dir_x = 1'b0;
      step(1);
      chk("track_to_return", ai_state, 2'd1);
      chk("return_keeps_dy", dy, 2'b01);
      ball_dir_x = 1'b1;
      step(1);
      chk("return_to_wait", ai_state, 2'd2);
      chk("wait_clears_dy", dy, 2'b00);
      ball_dir_x = 1'b0;
      step(1);
      chk("wait_abort", ai_state, 2'd1);
      step(1);
      chk("abort_return_dy", dy, 2'b01);

      // Low-x side approaches on ball_dir_x = 0
      side = 1'b1;
      step(1);
      chk("side1_wait", ai_state, 2'd2);
      side = 1'b0;
      step(1);
      chk("side0_return", ai_state, 2'd1);
      step(2);
      chk("side0_dy", dy, 2'b01);

      // Disable wins over pause
      pause  = 1'b1;
      enable = 1'b0;
      step(1);
      chk("disable_state", ai_state, 2'd0);
      chk("disable_dy", dy, 2'b00);
      enable = 1'b1;
      step(2);
      chk("paused_idle", ai_state, 2'd0);
      pause = 1'b0;
      step(1);
      chk("idle_to_return", ai_state, 2'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      n_fail++;
      $display("FAIL timeout: observed no finish, expected finish before 20000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/paddle_ai.md
PADDLE_AI -- requirements
Module: paddle_ai

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 10: width of all coordinate ports.
REQ-002 SHALL have parameter MAX_Y, default 480: playfield height; rest target is MAX_Y/2.
REQ-003 SHALL have parameter PADDLE_LENGTH, default 80: paddle height; paddle center = paddle_y + PADDLE_LENGTH/2.
REQ-004 SHALL have parameter DEAD_ZONE, default 4: error magnitude at or below which no move is requested.
REQ-005 SHALL have parameter REACT_CYCLES, default 3: reaction delay in unpaused cycles, minimum 1.
REQ-006 SHALL have parameter DECIDE_PERIOD, default 2: cycles between dy decisions, minimum 1.
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port enable, input, 1: 1 = AI drives the paddle, 0 = idle.
REQ-010 SHALL have port pause, input, 1: freezes all internal state.
REQ-011 SHALL have port side, input, 1: 0 = paddle on the high-x edge, 1 = paddle on the low-x edge.
REQ-012 SHALL have port ball_y, input, BIT_WIDTH: ball vertical position.
REQ-013 SHALL have port ball_dir_x, input, 1: 1 = ball moving toward +x.
REQ-014 SHALL have port paddle_y, input, BIT_WIDTH: current paddle position, fed back from the paddle block.
REQ-015 SHALL have port dy, output, 2: bit0 = move up (+y), bit1 = move down (-y); paddle command.
REQ-016 SHALL have port ai_state, output, 2: IDLE=0, RETURN=1, WAIT=2, TRACK=3.

Function
REQ-017 "Approaching" SHALL be (side==0 && ball_dir_x==1) || (side==1 && ball_dir_x==0).
REQ-018 IDLE: dy=00; enable=1 -> RETURN on the next edge.
REQ-019 RETURN: target = MAX_Y/2; approaching -> WAIT, loading react_cnt = REACT_CYCLES-1.
REQ-020 WAIT: dy forced to 00; react_cnt decrements each unpaused cycle; when react_cnt==0 -> TRACK; not approaching -> RETURN, which takes priority.
REQ-021 TRACK: target = ball_y; not approaching -> RETURN.
REQ-022 enable=0 in any state SHALL force IDLE and dy=00 on the next edge, overriding all other transitions.
REQ-023 Tick counter SHALL count 0..DECIDE_PERIOD-1 and wrap; tick asserts when count==DECIDE_PERIOD-1; counter runs in every unpaused cycle regardless of state.
REQ-024 On a tick in RETURN or TRACK, err = target - center SHALL be computed signed at BIT_WIDTH+2 bits with no truncation.
REQ-025 Tick decision: err > DEAD_ZONE -> dy=01; err < -DEAD_ZONE -> dy=10; otherwise dy=00.
REQ-026 Between ticks, dy SHALL hold its registered value; in RETURN/TRACK dy is therefore updated only on ticks.
REQ-027 dy SHALL be registered and SHALL never equal 11.
REQ-028 pause=1 SHALL hold state, react_cnt, tick counter and dy unchanged, except that enable=0 still forces IDLE.
REQ-029 Transition into RETURN or TRACK SHALL NOT clear dy; the first new value takes effect on the next tick.
REQ-030 ai_state SHALL reflect the registered state with zero latency.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously set state=IDLE, dy=00, react_cnt=0, tick counter=0.
REQ-032 Reset asserted mid-operation SHALL abandon any decision in progress; after release the block restarts from IDLE under the same rules.

Verification (defaults; center = paddle_y+40)
REQ-033 Reset: rst_n=0 mid-TRACK with dy=10 -> dy=00 and ai_state=0 before the next clk edge.
REQ-034 Return: enable=1, side=0, ball_dir_x=0, paddle_y=100 -> ai_state=1; at the first tick err=100 -> dy=01.
REQ-035 Reaction delay: from RETURN, set ball_dir_x=1 with ball_y=50, paddle_y=100 -> WAIT for 3 cycles with dy=00, then TRACK; at the next tick err=-90 -> dy=10.
REQ-036 Dead zone: TRACK, paddle_y=200 -> ball_y=244 gives dy=00; ball_y=245 gives dy=01; ball_y=235 gives dy=10.
REQ-037 Pause/abort: pause=1 during WAIT for 10 cycles -> react_cnt and dy frozen, resumes on release; ball_dir_x flips during WAIT -> RETURN; enable=0 -> IDLE, dy=00 next edge.
